// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: register count,
// address width and the write-enable classification used by both the
// write-decode stage and the register bank.
package regfile_pkg;

  localparam int NREG   = 8;
  localparam int ADDR_W = 3;
  localparam int POP_W  = 4;  // wide enough to hold a popcount of NREG bits

  // How a to_reg vector is interpreted on a clock edge.
  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_SINGLE = 2'd1,
    WR_MULTI  = 2'd2
  } wr_kind_e;

  // Number of asserted bits in a write-enable vector. Any X/Z bit makes the
  // sum unknown, which the classifier below folds into WR_MULTI.
  function automatic logic [POP_W-1:0] onehot_count(input logic [NREG-1:0] to_reg);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + POP_W'(to_reg[i]);
    end
    return cnt;
  endfunction

  // True only for a clean single-hot vector.
  function automatic logic is_onehot(input logic [NREG-1:0] to_reg);
    return (onehot_count(to_reg) == POP_W'(1));
  endfunction

  // Case matching is exact, so an unknown popcount never hits the idle or
  // single arms and lands in the multi-hot (error) arm.
  function automatic wr_kind_e classify(input logic [NREG-1:0] to_reg);
    wr_kind_e kind;
    case (onehot_count(to_reg))
      POP_W'(0): kind = WR_IDLE;
      POP_W'(1): kind = WR_SINGLE;
      default:   kind = WR_MULTI;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word of the register bank: loads d when en is high, clears
// asynchronously when reset_n is low.
module reg_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state: hold unless the word is enabled for a load.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves q_d unassigned (no latch).
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Storage flop with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: these words are cleared on reset because a never-written register must read 0, not X.
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/register_bank.sv
// Register bank fed by the write-decode stage: eight WIDTH-bit words written
// through a one-hot enable vector, two combinational read ports with optional
// same-cycle write bypass, per-word valid bits, a successful-write counter and
// a sticky flag for malformed (multi-hot) enables.
module register_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREG-1:0]   to_reg,
  input  logic [WIDTH-1:0]  wData,
  input  logic [ADDR_W-1:0] rAddr0,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  rData0,
  output logic [WIDTH-1:0]  rData1,
  output logic [NREG-1:0]   valid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              wr_err
);

  wr_kind_e          wr_kind;
  logic [NREG-1:0]   wr_en;
  logic [WIDTH-1:0]  word_q [NREG];

  logic [NREG-1:0]   valid_d;
  logic [NREG-1:0]   valid_q;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              wr_err_d;
  logic              wr_err_q;

  // Classify the enable vector; only a clean single-hot vector reaches the words.
  always_comb begin
    wr_kind = classify(to_reg);
    wr_en   = '0;
    if (wr_kind == WR_SINGLE) begin
      wr_en = to_reg;
    end
  end

  // Eight storage words, each loaded by its own enable bit.
  for (genvar g = 0; g < NREG; g++) begin : g_word
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_en[g]),
      .d       (wData),
      .q       (word_q[g])
    );
  end

  // Bookkeeping next-state: valid bits, write counter and sticky error.
  // A multi-hot edge sets the error even when clr_err is asserted alongside it.
  always_comb begin
    valid_d  = valid_q | wr_en;
    wr_cnt_d = wr_cnt_q;
    wr_err_d = wr_err_q;
    if (wr_kind == WR_SINGLE) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (wr_kind == WR_MULTI) begin
      wr_err_d = 1'b1;
    end else if (clr_err) begin
      wr_err_d = 1'b0;
    end
  end

  // Bookkeeping flops; the counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      wr_cnt_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_cnt_q <= wr_cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Read ports: storage mux, overridden by wData when bypass is enabled and
  // the addressed word is the one being written this cycle. wr_en is already
  // zero for idle or multi-hot vectors, so those never bypass.
  always_comb begin
    rData0 = word_q[rAddr0];
    rData1 = word_q[rAddr1];
    if (BYPASS != 0) begin
      if (wr_en[rAddr0]) begin
        rData0 = wData;
      end
      if (wr_en[rAddr1]) begin
        rData1 = wData;
      end
    end
  end

  assign valid  = valid_q;
  assign wr_cnt = wr_cnt_q;
  assign wr_err = wr_err_q;

endmodule
